fir_hdr_align: RTL and testbench
================================

# fir_hdr_align

Aligns encoder header words with the output of a pipelined FIR stage whose data latency is set at run time. Sits between the FIR datapath and the packetiser. Headers are held in a circular buffer. The first `cfg_dly` filter beats of each frame are dropped as pipeline priming. Every emitted data beat is paired with the header captured `cfg_dly` valid beats earlier. It supersedes the fixed-depth shift-register aligner with a runtime delay, frame-end handling, bypass and a configuration-error flag.

## Interface
Parameters:
- `DATA_WD`, 512, FIR data width.
- `HEAD_WD`, 64, encoder header width.
- `MAX_DLY`, 64, maximum delay in beats; must be a power of 2, at least 2.
- `DLY_WD`, localparam, clog2(MAX_DLY)+1.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_rst`  in  1  synchronous soft clear.
- `fir_en`  in  1  1 = align mode, 0 = bypass.
- `cfg_dly`  in  DLY_WD  FIR latency in valid beats.
- `fir_ivld`  in  1  input beat valid.
- `fir_idat`  in  DATA_WD  filtered data.
- `enc_idat`  in  HEAD_WD  header belonging to the current input beat.
- `fir_ilast`  in  1  last beat of frame; qualified by `fir_ivld`.
- `fir_ovld`  out  1  output valid.
- `fir_odat`  out  DATA_WD  output data.
- `enc_odat`  out  HEAD_WD  aligned header.
- `fir_olast`  out  1  frame end.
- `cfg_err`  out  1  sticky flag: `cfg_dly` > MAX_DLY was sampled.
- `stat_drop_cnt`  out  32  count of dropped priming beats.

## Operation
- **States:** BYPASS, PRIME, ALIGN.
- **Reset (`rst`):** state = BYPASS if `fir_en`=0, otherwise PRIME. All outputs are 0, and all pointers and counters are 0.
- **`cfg_rst`:** same effect as `rst`, applied synchronously. It overrides every other input. It also clears `cfg_err` and `stat_drop_cnt`.
- **Header ring:**
  - MAX_DLY entries of HEAD_WD.
  - Each `fir_ivld` writes `enc_idat` at `wr_ptr`, then `wr_ptr` += 1 modulo MAX_DLY.
  - The ring is written in every state.
- **Delay latch (`dly_q`):** `cfg_dly` is sampled into `dly_q` on entry to PRIME.
  - If `cfg_dly` > MAX_DLY, `dly_q` = MAX_DLY and `cfg_err` is set.
  - If `dly_q` = 0, the transition goes directly to ALIGN.
- **PRIME:**
  - Each `fir_ivld` increments `prime_cnt` and drops the beat (`fir_ovld`=0).
  - When `prime_cnt` reaches `dly_q`, move to ALIGN; the beat that completes the count is itself dropped.
  - `fir_ilast` in PRIME drops the beat, clears `prime_cnt`, and stays in PRIME with `cfg_dly` re-sampled.
- **ALIGN:**
  - Each `fir_ivld` emits `fir_odat` = `fir_idat` and `enc_odat` = ring[`wr_ptr` − `dly_q`] (modulo MAX_DLY), i.e. the header of the beat `dly_q` valid beats earlier.
  - When `dly_q` = MAX_DLY, the read happens before the same-cycle write; read-before-write is required.
  - When `dly_q` = 0, `enc_odat` = `enc_idat` of the same beat.
  - `fir_ilast` with `fir_ivld`: the beat is emitted with `fir_olast`=1, then the next state is PRIME with `prime_cnt` cleared.
- **BYPASS:** registered pass-through of `fir_ivld`, `fir_idat`, `enc_idat` and `fir_ilast`.
- **Leaving and entering bypass:**
  - `fir_en` falling in PRIME or ALIGN: the same cycle is already handled as BYPASS.
  - `fir_en` rising: the next state is PRIME.
- **Idle output:** on any cycle without an emitted beat, `fir_ovld`, `fir_odat`, `enc_odat` and `fir_olast` are driven 0.
- **Statistics:** `stat_drop_cnt` saturates at 0xFFFFFFFF.

## Timing
- Latency is 1 clock, input to output, in all states; there is no backpressure.
- `cfg_dly` is sampled only on entry to PRIME; changes while in ALIGN take effect at the next frame.
- `cfg_err` asserts 1 cycle after the bad value is sampled.
- Full throughput: `fir_ivld` may be high on every cycle.

## Configuration
- **`FIR_HDR_STAT_EN` defined:** `stat_drop_cnt` is implemented as described.
- **Not defined:** the counter logic is removed and `stat_drop_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- **Fixed delay:** `rst`, `fir_en`=1, `cfg_dly`=4, 10 back-to-back beats with `enc_idat`=0..9 and `fir_idat`=100..109.
  - Beats 100..103 are dropped.
  - Then 104..109 are emitted with headers 0..5.
  - `stat_drop_cnt`=4.
- **Full depth:** `cfg_dly`=64 (MAX_DLY), 70 beats with headers 0..69.
  - The first output is beat 64 with header 0.
  - The last output is beat 69 with header 5.
  - This checks read-before-write at full depth.
- **Frame end:** `cfg_dly`=2, frame of 5 beats with `fir_ilast` on beat 4, then `cfg_dly`=0 and 3 more beats.
  - First frame: beats 2..4 are emitted, with `fir_olast` on beat 4.
  - Second frame: all 3 beats are emitted with their own headers.
- **Bypass toggle:** `fir_en`=0 with gapped valids.
  - Output equals input delayed 1 cycle, including header and last.
  - Raising `fir_en` causes the next `cfg_dly` beats to be dropped.
- **Bad delay and `cfg_rst`:** `cfg_dly`=100.
  - `cfg_err`=1 and 64 beats are dropped.
  - Then pulse `cfg_rst` mid-ALIGN: all outputs are 0 the next cycle, and `cfg_err`=0 and `stat_drop_cnt`=0.
- **Async reset mid-frame:** assert `rst` asynchronously between clock edges during ALIGN.
  - All outputs go 0 immediately.
  - Re-priming is observed after release.

Source files
------------

// File: rtl/fir_hdr_align_if.sv
// ---------------------------------------------------------------------------
// fir_hdr_align_if
// Purpose : bundles the FIR-side beat stream (data, header, last) and the
//           aligned output stream of fir_hdr_align.
// Signals : fir_ivld/fir_idat/enc_idat/fir_ilast - input beat from FIR/encoder
//           fir_ovld/fir_odat/enc_odat/fir_olast - aligned beat to packetiser
// Modports: master - beat source / output sink (testbench, upstream glue)
//           slave  - the aligner itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface fir_hdr_align_if #(
  parameter int DATA_WD = 512,
  parameter int HEAD_WD = 64
);
  logic               fir_ivld;
  logic [DATA_WD-1:0] fir_idat;
  logic [HEAD_WD-1:0] enc_idat;
  logic               fir_ilast;
  logic               fir_ovld;
  logic [DATA_WD-1:0] fir_odat;
  logic [HEAD_WD-1:0] enc_odat;
  logic               fir_olast;

  modport master (
    output fir_ivld, fir_idat, enc_idat, fir_ilast,
    input  fir_ovld, fir_odat, enc_odat, fir_olast
  );

  modport slave (
    input  fir_ivld, fir_idat, enc_idat, fir_ilast,
    output fir_ovld, fir_odat, enc_odat, fir_olast
  );
endinterface

// File: rtl/fir_hdr_align.sv
// ---------------------------------------------------------------------------
// fir_hdr_align
// Purpose : pairs each beat leaving a pipelined FIR stage with the encoder
//           header that entered cfg_dly valid beats earlier. Headers live in
//           a MAX_DLY-deep ring; the first cfg_dly beats of every frame are
//           dropped while the filter pipeline primes. fir_en=0 gives a
//           registered pass-through. One clock of latency in every mode.
// Ports   : clk, rst (async, active high), cfg_rst (sync soft clear),
//           fir_en (1 = align, 0 = bypass), cfg_dly (delay in beats),
//           fir_bus (slave: input beat stream / aligned output stream),
//           cfg_err (sticky: cfg_dly > MAX_DLY sampled),
//           stat_drop_cnt (saturating count of dropped priming beats).
// Option  : define FIR_HDR_STAT_EN to implement stat_drop_cnt; otherwise the
//           counter is absent and the port reads 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fir_hdr_align #(
  parameter  int DATA_WD = 512,
  parameter  int HEAD_WD = 64,
  parameter  int MAX_DLY = 64,
  localparam int DLY_WD  = $clog2(MAX_DLY) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_rst,
  input  logic              fir_en,
  input  logic [DLY_WD-1:0] cfg_dly,
  fir_hdr_align_if.slave    fir_bus,
  output logic              cfg_err,
  output logic [31:0]       stat_drop_cnt
);

  localparam int                PTR_WD    = $clog2(MAX_DLY);
  localparam logic [DLY_WD-1:0] MAX_DLY_V = DLY_WD'(MAX_DLY);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_PRIME  = 2'd1,
    ST_ALIGN  = 2'd2
  } state_t;

  // r_state never holds BYPASS: fir_en=0 forces the effective state, so the
  // register only has to remember where to resume (always PRIME).
  state_t             r_state;
  state_t             w_cur;
  state_t             w_state_nxt;
  logic [PTR_WD-1:0]  r_wr_ptr;
  logic [DLY_WD-1:0]  r_prime_cnt;
  logic [DLY_WD-1:0]  w_cnt_nxt;
  logic [DLY_WD-1:0]  w_cnt_inc;
  logic [DLY_WD-1:0]  r_dly_q;
  logic [DLY_WD-1:0]  w_dly_nxt;
  logic [DLY_WD-1:0]  w_dly_sat;
  logic [DLY_WD-1:0]  w_dly;
  logic               w_dly_bad;
  logic               r_need_smp;
  logic               w_smp_nxt;
  logic               w_err_set;
  logic               r_cfg_err;
  logic               w_emit;
  logic [HEAD_WD-1:0] w_hdr_sel;
  logic [HEAD_WD-1:0] w_hdr_dly;
  logic [PTR_WD-1:0]  w_rd_idx;
  logic [HEAD_WD-1:0] r_ring [MAX_DLY];
  logic               r_ovld;
  logic               r_olast;
  logic [DATA_WD-1:0] r_odat;
  logic [HEAD_WD-1:0] r_ohdr;

  assign w_cur     = fir_en ? r_state : ST_BYPASS;
  assign w_dly_bad = (cfg_dly > MAX_DLY_V);
  assign w_dly_sat = w_dly_bad ? MAX_DLY_V : cfg_dly;
  // While a sample is pending the live (saturated) cfg_dly governs this beat.
  assign w_dly     = r_need_smp ? w_dly_sat : r_dly_q;
  assign w_cnt_inc = r_prime_cnt + {{(DLY_WD-1){1'b0}}, 1'b1};
  // A delay of MAX_DLY wraps to wr_ptr itself: the oldest entry, read before
  // this cycle's write overwrites it.
  assign w_rd_idx  = r_wr_ptr - w_dly[PTR_WD-1:0];
  assign w_hdr_dly = (w_dly == {DLY_WD{1'b0}}) ? fir_bus.enc_idat : r_ring[w_rd_idx];

  // Next-state, priming count, delay sampling and emit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_prime_cnt;
    w_dly_nxt   = r_dly_q;
    w_smp_nxt   = r_need_smp;
    w_err_set   = 1'b0;
    w_emit      = 1'b0;
    w_hdr_sel   = fir_bus.enc_idat;
    case (w_cur)
      ST_BYPASS: begin
        w_emit      = fir_bus.fir_ivld;
        w_hdr_sel   = fir_bus.enc_idat;
        w_state_nxt = ST_PRIME;
        w_cnt_nxt   = {DLY_WD{1'b0}};
        w_smp_nxt   = 1'b1;
      end
      ST_PRIME: begin
        // Sampling repeats until the frame's first beat commits the value.
        if (r_need_smp) begin
          w_dly_nxt = w_dly_sat;
          w_err_set = w_dly_bad;
        end else begin
          w_dly_nxt = r_dly_q;
        end
        if (w_dly == {DLY_WD{1'b0}}) begin
          // Zero delay: nothing to prime, this cycle already behaves as ALIGN.
          w_emit    = fir_bus.fir_ivld;
          w_hdr_sel = w_hdr_dly;
          w_cnt_nxt = {DLY_WD{1'b0}};
          if (fir_bus.fir_ivld && fir_bus.fir_ilast) begin
            w_state_nxt = ST_PRIME;
            w_smp_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_ALIGN;
            w_smp_nxt   = 1'b0;
          end
        end else if (fir_bus.fir_ivld) begin
          if (fir_bus.fir_ilast) begin
            w_cnt_nxt   = {DLY_WD{1'b0}};
            w_smp_nxt   = 1'b1;
            w_state_nxt = ST_PRIME;
          end else if (w_cnt_inc == w_dly) begin
            w_cnt_nxt   = {DLY_WD{1'b0}};
            w_smp_nxt   = 1'b0;
            w_state_nxt = ST_ALIGN;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_smp_nxt   = 1'b0;
            w_state_nxt = ST_PRIME;
          end
        end else begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_ALIGN: begin
        if (fir_bus.fir_ivld) begin
          w_emit    = 1'b1;
          w_hdr_sel = w_hdr_dly;
          if (fir_bus.fir_ilast) begin
            w_state_nxt = ST_PRIME;
            w_cnt_nxt   = {DLY_WD{1'b0}};
            w_smp_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_ALIGN;
          end
        end else begin
          w_state_nxt = ST_ALIGN;
        end
      end
      default: begin
        w_state_nxt = ST_PRIME;
        w_cnt_nxt   = {DLY_WD{1'b0}};
        w_smp_nxt   = 1'b1;
      end
    endcase
  end

  // Control state, pointers, sticky error and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_PRIME;
      r_wr_ptr    <= {PTR_WD{1'b0}};
      r_prime_cnt <= {DLY_WD{1'b0}};
      r_dly_q     <= {DLY_WD{1'b0}};
      r_need_smp  <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_ovld      <= 1'b0;
      r_olast     <= 1'b0;
      r_odat      <= {DATA_WD{1'b0}};
      r_ohdr      <= {HEAD_WD{1'b0}};
    end else if (cfg_rst) begin
      r_state     <= ST_PRIME;
      r_wr_ptr    <= {PTR_WD{1'b0}};
      r_prime_cnt <= {DLY_WD{1'b0}};
      r_dly_q     <= {DLY_WD{1'b0}};
      r_need_smp  <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_ovld      <= 1'b0;
      r_olast     <= 1'b0;
      r_odat      <= {DATA_WD{1'b0}};
      r_ohdr      <= {HEAD_WD{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_prime_cnt <= w_cnt_nxt;
      r_dly_q     <= w_dly_nxt;
      r_need_smp  <= w_smp_nxt;
      r_cfg_err   <= r_cfg_err | w_err_set;
      if (fir_bus.fir_ivld) begin
        r_wr_ptr <= r_wr_ptr + {{(PTR_WD-1){1'b0}}, 1'b1};
      end
      r_ovld  <= w_emit;
      r_olast <= w_emit & fir_bus.fir_ilast;
      r_odat  <= w_emit ? fir_bus.fir_idat : {DATA_WD{1'b0}};
      r_ohdr  <= w_emit ? w_hdr_sel : {HEAD_WD{1'b0}};
    end
  end

  // Header ring storage; written in every mode, data only so no reset.
  always_ff @(posedge clk) begin
    if (fir_bus.fir_ivld && !cfg_rst) begin
      r_ring[r_wr_ptr] <= fir_bus.enc_idat;
    end
  end

`ifdef FIR_HDR_STAT_EN
  logic        w_drop;
  logic [31:0] r_drop_cnt;

  assign w_drop = (w_cur == ST_PRIME) && fir_bus.fir_ivld && (w_dly != {DLY_WD{1'b0}});

  // Saturating count of beats discarded while priming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 32'd0;
    end else if (cfg_rst) begin
      r_drop_cnt <= 32'd0;
    end else if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
      r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign stat_drop_cnt = r_drop_cnt;
`else
  assign stat_drop_cnt = 32'd0;
`endif

  assign cfg_err           = r_cfg_err;
  assign fir_bus.fir_ovld  = r_ovld;
  assign fir_bus.fir_olast = r_olast;
  assign fir_bus.fir_odat  = r_odat;
  assign fir_bus.enc_odat  = r_ohdr;

endmodule

// File: tb/tb_fir_hdr_align.sv
`timescale 1ns/1ps
module tb_fir_hdr_align;
  localparam int DATA_WD = 512;
  localparam int HEAD_WD = 64;
  localparam int MAX_DLY = 64;
  localparam int DLY_WD  = 7;
`ifdef FIR_HDR_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_rst;
  logic              fir_en;
  logic [DLY_WD-1:0] cfg_dly;
  logic              cfg_err;
  logic [31:0]       stat_drop_cnt;
  int                errors = 0;
  int                checks = 0;

  fir_hdr_align_if #(.DATA_WD(DATA_WD), .HEAD_WD(HEAD_WD)) bus ();

  fir_hdr_align #(.DATA_WD(DATA_WD), .HEAD_WD(HEAD_WD), .MAX_DLY(MAX_DLY)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_rst       (cfg_rst),
    .fir_en        (fir_en),
    .cfg_dly       (cfg_dly),
    .fir_bus       (bus),
    .cfg_err       (cfg_err),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  // Drive one input cycle, clock it, and return 1 ns after the edge.
  task automatic beat(input logic v, input int d, input int h, input logic l);
    bus.fir_ivld  = v;
    bus.fir_idat  = DATA_WD'(d);
    bus.enc_idat  = HEAD_WD'(h);
    bus.fir_ilast = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic [DLY_WD-1:0] dly);
    fir_en = en;
    cfg_dly = dly;
    bus.fir_ivld = 1'b0;
    bus.fir_ilast = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [577:0] exp_beat(input logic v, input logic l, input int h, input int d);
    exp_beat = v ? {1'b1, l, HEAD_WD'(h), DATA_WD'(d)} : 578'd0;
  endfunction

  task automatic test_reset();
    logic [577:0] got;
    rst = 1'b1;
    fir_en = 1'b1;
    cfg_dly = 7'd4;
    beat(1'b1, 7, 7, 1'b1);
    got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
    checks++;
    if (got !== 578'd0) begin errors++; $display("FAIL reset_out: got %h want 0", got); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    checks++;
    if (stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_stat: got %0d want 0", stat_drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_delay();
    logic [577:0] got, exp;
    do_reset(1'b1, 7'd4);
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 100 + i, i, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 4, 1'b0, i - 4, 100 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fixed_beat%0d: got %h want %h", i, got, exp); end
    end
    beat(1'b0, 0, 0, 1'b0);
    checks++;
    if (bus.fir_ovld !== 1'b0) begin errors++; $display("FAIL fixed_idle: got %b want 0", bus.fir_ovld); end
    checks++;
    if (stat_drop_cnt !== (STAT_ON ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL fixed_stat: got %0d want %0d", stat_drop_cnt, STAT_ON ? 4 : 0);
    end
  endtask

  task automatic test_full_depth();
    logic [577:0] got, exp;
    do_reset(1'b1, 7'd64);
    for (int i = 0; i < 70; i++) begin
      beat(1'b1, 1000 + i, i, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 64, 1'b0, i - 64, 1000 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL full_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_frame_end();
    logic [577:0] got, exp;
    do_reset(1'b1, 7'd2);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 200 + i, 10 + i, i == 4);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 2, i == 4, 10 + i - 2, 200 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL frame1_beat%0d: got %h want %h", i, got, exp); end
    end
    cfg_dly = 7'd0;
    for (int j = 0; j < 3; j++) begin
      beat(1'b1, 300 + j, 20 + j, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(1'b1, 1'b0, 20 + j, 300 + j);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL frame2_beat%0d: got %h want %h", j, got, exp); end
    end
  endtask

  task automatic test_bypass();
    logic [577:0] got, exp;
    logic [5:0]   vpat;
    vpat = 6'b101101;
    do_reset(1'b0, 7'd3);
    for (int i = 0; i < 6; i++) begin
      beat(vpat[i], 400 + i, 50 + i, i == 3);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(vpat[i], i == 3, 50 + i, 400 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bypass_beat%0d: got %h want %h", i, got, exp); end
    end
    fir_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 600 + i, 60 + i, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 3, 1'b0, 60 + i - 3, 600 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reenable_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_bad_delay();
    logic [577:0] got, exp;
    do_reset(1'b1, 7'd100);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad_err_pre: got %b want 0", cfg_err); end
    for (int i = 0; i < 66; i++) begin
      beat(1'b1, 500 + i, i, 1'b0);
      if (i == 0) begin
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b want 1", cfg_err); end
      end
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 64, 1'b0, i - 64, 500 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bad_beat%0d: got %h want %h", i, got, exp); end
    end
    checks++;
    if (stat_drop_cnt !== (STAT_ON ? 32'd64 : 32'd0)) begin
      errors++; $display("FAIL bad_stat: got %0d want %0d", stat_drop_cnt, STAT_ON ? 64 : 0);
    end
    cfg_rst = 1'b1;
    beat(1'b1, 999, 999, 1'b1);
    cfg_rst = 1'b0;
    got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
    checks++;
    if (got !== 578'd0) begin errors++; $display("FAIL cfgrst_out: got %h want 0", got); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgrst_err: got %b want 0", cfg_err); end
    checks++;
    if (stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL cfgrst_stat: got %0d want 0", stat_drop_cnt); end
  endtask

  task automatic test_async_reset();
    logic [577:0] got, exp;
    do_reset(1'b1, 7'd1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 700 + i, 70 + i, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 1, 1'b0, 70 + i - 1, 700 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL async_pre_beat%0d: got %h want %h", i, got, exp); end
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
    checks++;
    if (got !== 578'd0) begin errors++; $display("FAIL async_out: got %h want 0", got); end
    #2;
    rst = 1'b0;
    cfg_dly = 7'd2;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 800 + i, 80 + i, 1'b0);
      got = {bus.fir_ovld, bus.fir_olast, bus.enc_odat, bus.fir_odat};
      exp = exp_beat(i >= 2, 1'b0, 80 + i - 2, 800 + i);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL async_post_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_rst = 1'b0;
    fir_en = 1'b1;
    cfg_dly = 7'd0;
    bus.fir_ivld = 1'b0;
    bus.fir_idat = '0;
    bus.enc_idat = '0;
    bus.fir_ilast = 1'b0;
    test_reset();
    test_fixed_delay();
    test_full_depth();
    test_frame_end();
    test_bypass();
    test_bad_delay();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
